// File: rtl/dmem_ws.sv
// Wait-stated data memory with req/ready handshake, byte/half/word lanes,
// misalignment rejection and a sticky write-1-to-clear FP flag register.
module dmem_ws #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] FLAGS_ADDR  = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        misalign,
    input  logic [2:0]  fp_exc,
    output logic [2:0]  fp_flags
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        commit;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] res_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          mis;
    logic          is_flag;
    logic [AW-1:0] idx;
    logic [31:0]   word_rd;
    logic [31:0]   shifted;
    logic [31:0]   wshift;
    logic [3:0]    mask;
    logic [31:0]   merged;
    logic [31:0]   load_val;
    logic          flag_wr;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    commit   = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                // With no wait states the commit edge is the DONE edge itself.
                if (WAIT_STATES == 0) commit = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mis = (size_q == 2'b11)
            | ((size_q == 2'b01) & addr_q[0])
            | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00));
        is_flag = (addr_q[31:2] == FLAGS_ADDR[31:2]);
        idx     = addr_q[AW+1:2];
        word_rd = is_flag ? {29'b0, fp_flags} : mem[idx];
        shifted = word_rd >> {addr_q[1:0], 3'b000};
        wshift  = wdata_q << {addr_q[1:0], 3'b000};

        load_val = '0;
        if (!we_q && !mis) begin
            case (size_q)
                2'b00: load_val = uns_q ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
                2'b01: load_val = uns_q ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
                2'b10: load_val = word_rd;
                default: load_val = '0;
            endcase
        end

        case (size_q)
            2'b00:   mask = 4'b0001 << addr_q[1:0];
            2'b01:   mask = 4'b0011 << {addr_q[1], 1'b0};
            default: mask = 4'b1111;
        endcase

        merged = word_rd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i]) merged[8*i +: 8] = wshift[8*i +: 8];
        end

        flag_wr = commit && we_q && !mis && is_flag;
    end

    // Array is deliberately left unreset; writes only happen on a real commit.
    always_ff @(posedge clk) begin
        if (commit && we_q && !mis && !is_flag) mem[idx] <= merged;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rdata    <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            misalign <= 1'b0;
            fp_flags <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            res_q    <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            busy     <= (state_nx != IDLE);
            ready    <= (state == DONE);
            misalign <= (state == DONE) && mis;

            if (state == IDLE && req) begin
                we_q    <= we;
                size_q  <= size;
                uns_q   <= uns;
                addr_q  <= addr;
                wdata_q <= wdata;
            end

            if (commit) res_q <= load_val;
            if (state == DONE) rdata <= (WAIT_STATES == 0) ? load_val : res_q;

            if (flag_wr) fp_flags <= (fp_flags & ~wdata_q[2:0]) | fp_exc;
            else         fp_flags <= fp_flags | fp_exc;
        end
    end

endmodule

// File: tb/tb_dmem_ws.sv
// Scoreboard bench for dmem_ws: main instance with 2 wait states, plus
// 0 and 5 wait-state instances for latency comparison.
module tb_dmem_ws;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  fp_exc;

    logic [31:0] rdata,  rdata0,  rdata5;
    logic        ready,  ready0,  ready5;
    logic        busy,   busy0,   busy5;
    logic        misalign, misalign0, misalign5;
    logic [2:0]  fp_flags, fp_flags0, fp_flags5;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] rd;
        logic        chk_rd;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    dmem_ws #(.DEPTH_WORDS(64), .WAIT_STATES(2), .FLAGS_ADDR(32'hFFFF_FFF0)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
        .misalign(misalign), .fp_exc(fp_exc), .fp_flags(fp_flags)
    );

    dmem_ws #(.DEPTH_WORDS(64), .WAIT_STATES(0), .FLAGS_ADDR(32'hFFFF_FFF0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .busy(busy0),
        .misalign(misalign0), .fp_exc(fp_exc), .fp_flags(fp_flags0)
    );

    dmem_ws #(.DEPTH_WORDS(64), .WAIT_STATES(5), .FLAGS_ADDR(32'hFFFF_FFF0)) dut5 (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .rdata(rdata5), .ready(ready5), .busy(busy5),
        .misalign(misalign5), .fp_exc(fp_exc), .fp_flags(fp_flags5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one access on the main instance, scramble the request fields after
    // the accept edge, then wait (bounded) for ready and score the result.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] erd, input logic emis, input string nm);
        exp_t e;
        bit   got;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        e.rd = erd; e.chk_rd = !w || emis; e.mis = emis;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0; we = ~w; size = 2'b10; uns = ~u; addr = 32'h0000_003C; wdata = 32'h0BAD_F00D;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (ready) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            $display("FAIL %s timeout: ready=0 required 1", nm);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            $display("FAIL %s: ready with empty scoreboard, required pending entry", nm);
        end else begin
            e = sb.pop_front();
            if (misalign !== e.mis)
                $display("FAIL %s misalign: got %b required %b", nm, misalign, e.mis);
            else
                passed++;
            if (e.chk_rd) begin
                checks++;
                if (rdata !== e.rd)
                    $display("FAIL %s rdata: got %h required %h", nm, rdata, e.rd);
                else
                    passed++;
            end
        end
    endtask

    task automatic check_zero_outputs(input string nm);
        checks++;
        if (rdata !== 32'h0) $display("FAIL %s rdata: got %h required 0", nm, rdata); else passed++;
        checks++;
        if (ready !== 1'b0) $display("FAIL %s ready: got %b required 0", nm, ready); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy: got %b required 0", nm, busy); else passed++;
        checks++;
        if (misalign !== 1'b0) $display("FAIL %s misalign: got %b required 0", nm, misalign); else passed++;
        checks++;
        if (fp_flags !== 3'b000) $display("FAIL %s fp_flags: got %b required 000", nm, fp_flags); else passed++;
    endtask

    task automatic test_reset;
        check_zero_outputs("reset");
        checks++;
        if (ready0 !== 1'b0 || busy5 !== 1'b0)
            $display("FAIL reset_variants: ready0=%b busy5=%b required 0 0", ready0, busy5);
        else
            passed++;
    endtask

    task automatic test_latency;
        int lat0 = -1, lat2 = -1, lat5 = -1;
        int n0 = 0, n2 = 0, n5 = 0;
        int b0 = 0, b2 = 0, b5 = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'h1111_1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) req = 1'b0;
            if (ready0) begin n0++; if (lat0 < 0) lat0 = c; end
            if (ready)  begin n2++; if (lat2 < 0) lat2 = c; end
            if (ready5) begin n5++; if (lat5 < 0) lat5 = c; end
            if (busy0 !== ((c <= 0) ? 1'b1 : 1'b0)) b0++;
            if (busy  !== ((c <= 2) ? 1'b1 : 1'b0)) b2++;
            if (busy5 !== ((c <= 5) ? 1'b1 : 1'b0)) b5++;
        end
        checks++; if (lat0 !== 1) $display("FAIL latency_ws0: got %0d required 1", lat0); else passed++;
        checks++; if (lat2 !== 3) $display("FAIL latency_ws2: got %0d required 3", lat2); else passed++;
        checks++; if (lat5 !== 6) $display("FAIL latency_ws5: got %0d required 6", lat5); else passed++;
        checks++; if (n0 !== 1) $display("FAIL pulse_ws0: got %0d cycles required 1", n0); else passed++;
        checks++; if (n2 !== 1) $display("FAIL pulse_ws2: got %0d cycles required 1", n2); else passed++;
        checks++; if (n5 !== 1) $display("FAIL pulse_ws5: got %0d cycles required 1", n5); else passed++;
        checks++; if (b0 !== 0) $display("FAIL busy_ws0: got %0d bad cycles required 0", b0); else passed++;
        checks++; if (b2 !== 0) $display("FAIL busy_ws2: got %0d bad cycles required 0", b2); else passed++;
        checks++; if (b5 !== 0) $display("FAIL busy_ws5: got %0d bad cycles required 0", b5); else passed++;
    endtask

    task automatic test_lanes;
        do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'h8070_6050, 32'h0,         1'b0, "sw_0x10");
        do_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'hFFFF_FF80, 1'b0, "lb_0x13");
        do_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         32'h0000_0080, 1'b0, "lbu_0x13");
        do_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'hFFFF_8070, 1'b0, "lh_0x12");
        do_access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0,         32'h0000_6050, 1'b0, "lhu_0x10");
        do_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA, 32'h0,         1'b0, "sb_0x11");
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h8070_AA50, 1'b0, "lw_after_sb");
    endtask

    task automatic test_misalign;
        do_access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0,         32'h0, 1'b1, "lw_0x12");
        do_access(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_FFFF, 32'h0, 1'b1, "sh_0x11");
        do_access(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, "size11_store");
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8070_AA50, 1'b0, "lw_unchanged");
    endtask

    task automatic test_flags;
        @(negedge clk); fp_exc = 3'b010;
        @(negedge clk); fp_exc = 3'b000;
        @(negedge clk);
        checks++;
        if (fp_flags !== 3'b010) $display("FAIL flag_set: got %b required 010", fp_flags); else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (fp_flags !== 3'b010) $display("FAIL flag_sticky: got %b required 010", fp_flags); else passed++;
        fp_exc = 3'b100;
        do_access(1'b1, 2'b10, 1'b0, 32'hFFFF_FFF0, 32'h2, 32'h0, 1'b0, "flag_store");
        fp_exc = 3'b000;
        @(negedge clk);
        checks++;
        if (fp_flags !== 3'b100) $display("FAIL flag_w1c: got %b required 100", fp_flags); else passed++;
        do_access(1'b0, 2'b10, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0000_0004, 1'b0, "flag_load");
        do_access(1'b0, 2'b00, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h0000_0004, 1'b0, "flag_lbu");
        do_access(1'b0, 2'b10, 1'b0, 32'hFFFF_FFF2, 32'h0, 32'h0,         1'b1, "flag_lw_mis");
    endtask

    task automatic test_alias;
        do_access(1'b1, 2'b10, 1'b0, 32'h100, 32'h0000_1234, 32'h0,         1'b0, "sw_0x100");
        do_access(1'b0, 2'b10, 1'b0, 32'h000, 32'h0,         32'h0000_1234, 1'b0, "lw_alias_0x0");
        do_access(1'b1, 2'b10, 1'b0, 32'h0FC, 32'hCAFE_F00D, 32'h0,         1'b0, "sw_last");
        do_access(1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0,         32'hCAFE_F00D, 1'b0, "lw_alias_last");
    endtask

    task automatic test_reset_mid_wait;
        do_access(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 32'h0,         1'b0, "sw_0x20");
        do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'h1122_3344, 1'b0, "lw_0x20");
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h20; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset_mid_wait");
        reset = 1'b1;
        do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1122_3344, 1'b0, "lw_after_abort");
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = '0; wdata = '0; fp_exc = 3'b000;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_latency();
        test_lanes();
        test_misalign();
        test_flags();
        test_alias();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
